// File: rtl/mem_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mem_stage_if                                           |
// | Description : Execute-to-memory and memory-to-write-back handshake   |
// |               and payload signals of the memory pipeline stage.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface mem_stage_if #(
  parameter int EX_WD = 48
);
  logic             es_to_ms_valid;
  logic             ms_allowin;
  logic [102:0]     es_to_ms_bus;
  logic [6:0]       es_load_mem_bus;
  logic             es_ex;
  logic [EX_WD-1:0] es_ex_bus;
  logic [31:0]      data_sram_rdata;
  logic             ws_allowin;
  logic             ms_to_ws_valid;
  logic [69:0]      ms_to_ws_bus;
  logic [EX_WD-1:0] ms_ex_bus;
  logic             ms_ex;
  logic             flush;
  logic             ms_write_reg;
  logic [4:0]       ms_reg_dest;
  logic [31:0]      ms_to_ds_bus;

  // Upstream/environment side: drives execute bundle, SRAM data, back-pressure, flush.
  modport master (
    output es_to_ms_valid, es_to_ms_bus, es_load_mem_bus, es_ex, es_ex_bus,
    output data_sram_rdata, ws_allowin, flush,
    input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_ex_bus, ms_ex,
    input  ms_write_reg, ms_reg_dest, ms_to_ds_bus
  );

  // Memory stage side.
  modport slave (
    input  es_to_ms_valid, es_to_ms_bus, es_load_mem_bus, es_ex, es_ex_bus,
    input  data_sram_rdata, ws_allowin, flush,
    output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_ex_bus, ms_ex,
    output ms_write_reg, ms_reg_dest, ms_to_ds_bus
  );
endinterface
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mem_stage                                              |
// | Description : MIPS memory stage - pipeline register, SRAM read-data  |
// |               hold buffer, load alignment and sign/zero extension.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module mem_stage #(
  parameter int EX_WD = 48
) (
  input  wire logic   clk,
  input  wire logic   reset,
  mem_stage_if.slave  ms_if
);

  logic             r_ms_valid;
  logic             r_ms_first;
  logic [31:0]      r_rdata_buf;
  logic [102:0]     r_es_to_ms_bus;
  logic [6:0]       r_load_bus;
  logic             r_es_ex;
  logic [EX_WD-1:0] r_ex_bus;

  logic             w_allowin;
  logic             w_accept;
  logic [31:0]      w_data;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [31:0]      w_load_result;
  logic [31:0]      w_final_result;

  // Payload fields of the held bundle.
  wire logic        w_res_from_mem = r_es_to_ms_bus[102];
  wire logic        w_gr_we        = r_es_to_ms_bus[101];
  wire logic [4:0]  w_dest         = r_es_to_ms_bus[100:96];
  wire logic [31:0] w_alu_result   = r_es_to_ms_bus[95:64];
  wire logic [31:0] w_rt_value     = r_es_to_ms_bus[63:32];
  wire logic [31:0] w_pc           = r_es_to_ms_bus[31:0];
  wire logic [1:0]  w_width        = r_load_bus[6:5];
  wire logic        w_sign         = r_load_bus[4];
  wire logic [1:0]  w_lr           = r_load_bus[3:2];
  wire logic [1:0]  w_addr_lo      = r_load_bus[1:0];

  assign w_allowin = !r_ms_valid || ms_if.ws_allowin;
  assign w_accept  = ms_if.es_to_ms_valid && w_allowin;

  // Stage valid flag; flush kills the held bundle and wins over an accept.
  always_ff @(posedge clk) begin
    if (reset || ms_if.flush) begin
      r_ms_valid <= 1'b0;
    end else if (w_allowin) begin
      r_ms_valid <= ms_if.es_to_ms_valid;
    end
  end

  // Marks the single cycle in which the SRAM output belongs to this bundle.
  always_ff @(posedge clk) begin
    if (reset || ms_if.flush) begin
      r_ms_first <= 1'b0;
    end else begin
      r_ms_first <= w_accept;
    end
  end

  // Keep the read data so a stalled load survives the SRAM output changing.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata_buf <= 32'd0;
    end else if (r_ms_first) begin
      r_rdata_buf <= ms_if.data_sram_rdata;
    end
  end

  // Pipeline register for the execute bundle and its exception side-band.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_es_to_ms_bus <= '0;
      r_load_bus     <= '0;
      r_es_ex        <= 1'b0;
      r_ex_bus       <= '0;
    end else if (w_accept) begin
      r_es_to_ms_bus <= ms_if.es_to_ms_bus;
      r_load_bus     <= ms_if.es_load_mem_bus;
      r_es_ex        <= ms_if.es_ex;
      r_ex_bus       <= ms_if.es_ex_bus;
    end
  end

  assign w_data = r_ms_first ? ms_if.data_sram_rdata : r_rdata_buf;
  assign w_half = w_addr_lo[1] ? w_data[31:16] : w_data[15:0];

  // Load alignment: lane select, extension and LWL/LWR merge with rt.
  always_comb begin
    w_load_result = w_data;
    case (w_addr_lo)
      2'd0:    w_byte = w_data[7:0];
      2'd1:    w_byte = w_data[15:8];
      2'd2:    w_byte = w_data[23:16];
      default: w_byte = w_data[31:24];
    endcase
    case (w_width)
      2'b11: w_load_result = w_data;
      2'b10: w_load_result = {{16{w_sign & w_half[15]}}, w_half};
      2'b01: w_load_result = {{24{w_sign & w_byte[7]}}, w_byte};
      default: begin
        if (w_lr == 2'b10) begin
          case (w_addr_lo)
            2'd0:    w_load_result = {w_data[7:0],  w_rt_value[23:0]};
            2'd1:    w_load_result = {w_data[15:0], w_rt_value[15:0]};
            2'd2:    w_load_result = {w_data[23:0], w_rt_value[7:0]};
            default: w_load_result = w_data;
          endcase
        end else if (w_lr == 2'b01) begin
          case (w_addr_lo)
            2'd0:    w_load_result = w_data;
            2'd1:    w_load_result = {w_rt_value[31:24], w_data[31:8]};
            2'd2:    w_load_result = {w_rt_value[31:16], w_data[31:16]};
            default: w_load_result = {w_rt_value[31:8],  w_data[31:24]};
          endcase
        end
      end
    endcase
  end

  assign w_final_result = w_res_from_mem ? w_load_result : w_alu_result;

  assign ms_if.ms_allowin     = w_allowin;
  assign ms_if.ms_to_ws_valid = r_ms_valid;
  assign ms_if.ms_to_ws_bus   = {w_gr_we, w_dest, w_final_result, w_pc};
  assign ms_if.ms_ex_bus      = r_ex_bus;
  assign ms_if.ms_ex          = r_ms_valid & r_es_ex;
  assign ms_if.ms_write_reg   = r_ms_valid & w_gr_we;
  assign ms_if.ms_reg_dest    = w_dest;
  assign ms_if.ms_to_ds_bus   = w_final_result;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_mem_stage                                           |
// | Description : Self-checking bench for mem_stage with a byte-level    |
// |               reference model of the load instructions.              |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_mem_stage;
  localparam int EX_WD = 48;

  typedef enum logic [2:0] {OP_ALU, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR} op_e;

  typedef struct {
    op_e              op;
    logic [1:0]       addr;
    logic [31:0]      alu;
    logic [31:0]      rt;
    logic [31:0]      pc;
    logic [4:0]       dest;
    logic             we;
    logic             ex;
    logic [EX_WD-1:0] exbus;
  } bundle_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_stage_if #(.EX_WD(EX_WD)) bus ();
  mem_stage #(.EX_WD(EX_WD)) dut (.clk(clk), .reset(reset), .ms_if(bus));

  int n_cmp = 0;
  int n_err = 0;

  // Stimulus for the next cycle.
  bundle_t     s_b;
  logic        s_valid, s_ws, s_flush, s_reset;
  logic [31:0] s_first_data, s_later_data;

  // Reference model state.
  bundle_t     m_b;
  logic        m_valid = 1'b0;
  logic        m_first = 1'b0;
  logic [31:0] m_result = '0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Architectural result of a load given the memory word and old rt.
  function automatic logic [31:0] ref_load(op_e op, logic [1:0] a, logic [31:0] d, logic [31:0] rt);
    logic [7:0] db[4];
    logic [7:0] rb[4];
    logic [7:0] res[4];
    int ai;
    ai = int'(a);
    for (int i = 0; i < 4; i++) begin
      db[i] = d[8*i +: 8];
      rb[i] = rt[8*i +: 8];
      res[i] = rb[i];
    end
    case (op)
      OP_LB:  return {{24{db[ai][7]}}, db[ai]};
      OP_LBU: return {24'd0, db[ai]};
      OP_LH:  return {{16{db[2*(ai/2)+1][7]}}, db[2*(ai/2)+1], db[2*(ai/2)]};
      OP_LHU: return {16'd0, db[2*(ai/2)+1], db[2*(ai/2)]};
      OP_LW:  return d;
      OP_LWL: begin
        for (int i = 0; i < 4; i++) if (i >= 3 - ai) res[i] = db[i - (3 - ai)];
        return {res[3], res[2], res[1], res[0]};
      end
      OP_LWR: begin
        for (int i = 0; i < 4; i++) if (i <= 3 - ai) res[i] = db[i + ai];
        return {res[3], res[2], res[1], res[0]};
      end
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [6:0] enc_load(op_e op, logic [1:0] a);
    case (op)
      OP_LB:   return {2'b01, 1'b1, 2'b00, a};
      OP_LBU:  return {2'b01, 1'b0, 2'b00, a};
      OP_LH:   return {2'b10, 1'b1, 2'b00, a};
      OP_LHU:  return {2'b10, 1'b0, 2'b00, a};
      OP_LWL:  return {2'b00, 1'b0, 2'b10, a};
      OP_LWR:  return {2'b00, 1'b0, 2'b01, a};
      default: return {2'b11, 1'b0, 2'b00, a};
    endcase
  endfunction

  task automatic set_op(input op_e op, input logic [1:0] a, input logic [31:0] alu, input logic [31:0] rt);
    s_b.op = op; s_b.addr = a; s_b.alu = alu; s_b.rt = rt;
    s_b.pc = $urandom; s_b.dest = 5'($urandom); s_b.we = 1'b1;
    s_b.ex = 1'b0; s_b.exbus = {16'($urandom), 32'($urandom)};
  endtask

  // One clock: drive inputs, check outputs against the model, advance the model.
  task automatic step();
    logic allow, acc;
    @(negedge clk);
    if (m_first)
      m_result = (m_b.op == OP_ALU) ? m_b.alu : ref_load(m_b.op, m_b.addr, s_first_data, m_b.rt);
    bus.es_to_ms_valid  = s_valid;
    bus.es_to_ms_bus    = {s_b.op != OP_ALU, s_b.we, s_b.dest, s_b.alu, s_b.rt, s_b.pc};
    bus.es_load_mem_bus = enc_load(s_b.op, s_b.addr);
    bus.es_ex           = s_b.ex;
    bus.es_ex_bus       = s_b.exbus;
    bus.ws_allowin      = s_ws;
    bus.flush           = s_flush;
    bus.data_sram_rdata = m_first ? s_first_data : s_later_data;
    reset               = s_reset;
    #1;
    allow = !m_valid || s_ws;
    check("valid", bus.ms_to_ws_valid, m_valid);
    check("allowin", bus.ms_allowin, allow);
    check("ms_ex", bus.ms_ex, m_valid & m_b.ex);
    check("write_reg", bus.ms_write_reg, m_valid & m_b.we);
    if (m_valid) begin
      check("ws_bus", bus.ms_to_ws_bus, {m_b.we, m_b.dest, m_result, m_b.pc});
      check("ds_bus", bus.ms_to_ds_bus, m_result);
      check("reg_dest", bus.ms_reg_dest, m_b.dest);
      check("ex_bus", bus.ms_ex_bus, m_b.exbus);
    end
    acc = s_valid && allow;
    if (s_reset || s_flush) begin
      m_valid = 1'b0;
      m_first = 1'b0;
    end else begin
      if (allow) m_valid = s_valid;
      m_first = acc;
      if (acc) m_b = s_b;
    end
  endtask

  // Issue a single load, then present its data with write-back stalled.
  task automatic one_load(input string tag, input op_e op, input logic [1:0] a,
                          input logic [31:0] rt, input logic [31:0] d, input logic [31:0] exp);
    set_op(op, a, $urandom, rt);
    s_valid = 1'b1; s_ws = 1'b1; step();
    s_valid = 1'b0; s_ws = 1'b0; s_first_data = d; s_later_data = ~d; step();
    check(tag, bus.ms_to_ds_bus, exp);
    s_ws = 1'b1; step();
  endtask

  initial begin
    s_valid = 0; s_ws = 1; s_flush = 0; s_reset = 0;
    s_first_data = 0; s_later_data = 0;
    set_op(OP_ALU, 2'd0, 32'd0, 32'd0);
    m_b = s_b;
    bus.es_to_ms_valid = 0; bus.es_to_ms_bus = '0; bus.es_load_mem_bus = '0;
    bus.es_ex = 0; bus.es_ex_bus = '0; bus.data_sram_rdata = '0;
    bus.ws_allowin = 1; bus.flush = 0;
    reset = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 0;
    #1;
    check("rst_valid", bus.ms_to_ws_valid, 1'b0);
    check("rst_ex", bus.ms_ex, 1'b0);
    check("rst_write_reg", bus.ms_write_reg, 1'b0);
    check("rst_ws_bus", bus.ms_to_ws_bus, 70'd0);
    check("rst_ex_bus", bus.ms_ex_bus, 48'd0);

    // Directed load alignment cases.
    one_load("lb_tp",  OP_LB,  2'd3, 32'h0,         32'h80FF_1234, 32'hFFFF_FF80);
    one_load("lbu_tp", OP_LBU, 2'd3, 32'h0,         32'h80FF_1234, 32'h0000_0080);
    one_load("lwl_tp", OP_LWL, 2'd1, 32'h1122_3344, 32'hAABB_CCDD, 32'hCCDD_3344);
    one_load("lwr_tp", OP_LWR, 2'd1, 32'h1122_3344, 32'hAABB_CCDD, 32'h11AA_BBCC);
    one_load("lh_hi",  OP_LH,  2'd2, 32'h0,         32'h8001_7FFF, 32'hFFFF_8001);

    // Stalled LW keeps first-cycle data while SRAM output changes.
    set_op(OP_LW, 2'd0, $urandom, $urandom);
    s_valid = 1; s_ws = 1; step();
    s_valid = 0; s_ws = 0; s_first_data = 32'h1234_5678; s_later_data = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_hold", bus.ms_to_ds_bus, 32'h1234_5678);
    end
    s_ws = 1; step();
    check("stall_issue", bus.ms_to_ws_valid, 1'b1);
    step();
    check("stall_once", bus.ms_to_ws_valid, 1'b0);

    // Back-to-back ALU bundles.
    set_op(OP_ALU, 2'd0, 32'h10, $urandom);
    s_valid = 1; s_ws = 1; step();
    for (int i = 0; i < 4; i++) begin
      s_b.pc = $urandom;
      step();
      check("b2b_valid", bus.ms_to_ws_valid, 1'b1);
      check("b2b_ds", bus.ms_to_ds_bus, 32'h10);
      check("b2b_wr", bus.ms_write_reg, 1'b1);
    end
    s_valid = 0; step();

    // Flush coinciding with an accept.
    set_op(OP_ALU, 2'd0, $urandom, $urandom);
    s_b.ex = 1; s_valid = 1; s_flush = 1; step();
    s_valid = 0; s_flush = 0; step();
    check("flush_valid", bus.ms_to_ws_valid, 1'b0);
    check("flush_ex", bus.ms_ex, 1'b0);

    // Exception bundle held for two stall cycles.
    set_op(OP_LW, 2'd0, $urandom, $urandom);
    s_b.ex = 1; s_b.exbus = 48'hABCD_1234_5678;
    s_valid = 1; s_ws = 1; step();
    s_valid = 0; s_ws = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      check("ex_held", bus.ms_ex, 1'b1);
      check("ex_bus_tp", bus.ms_ex_bus, 48'hABCD_1234_5678);
    end
    s_ws = 1; step();
    step();
    check("ex_drop", bus.ms_ex, 1'b0);

    // Randomized traffic with stalls, flushes and occasional reset.
    for (int n = 0; n < 600; n++) begin
      op_e op;
      logic [1:0] a;
      op = op_e'($urandom_range(0, 7));
      a  = 2'($urandom);
      if (op == OP_LH || op == OP_LHU) a[0] = 1'b0;
      if (op == OP_LW) a = 2'd0;
      set_op(op, a, $urandom, $urandom);
      s_b.we = 1'($urandom);
      s_b.ex = ($urandom_range(0, 7) == 0);
      s_valid = ($urandom_range(0, 3) != 0);
      s_ws    = ($urandom_range(0, 3) != 0);
      s_flush = ($urandom_range(0, 24) == 0);
      s_reset = ($urandom_range(0, 79) == 0);
      s_first_data = $urandom;
      s_later_data = $urandom;
      step();
    end
    s_valid = 0; s_flush = 0; s_reset = 0; s_ws = 1;
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Fourth pipeline stage of the five-stage MIPS core, between the execute stage and the write-back stage. Receives the execute result bundle and load descriptor, captures the synchronous data-SRAM read data, and performs load alignment (LB/LBU/LH/LHU/LW/LWL/LWR) and sign/zero extension. Forwards the final result to decode for bypassing and raises exception status for the CP0 flush logic. Supports back-pressure from write-back without losing SRAM read data.

## Interface
- EX_WD, 48, width of the exception side-bus passed through unchanged to write-back.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- es_to_ms_valid  in  1  execute bundle valid.
- ms_allowin  out  1  stage can accept a bundle this cycle.
- es_to_ms_bus  in  103  {res_from_mem[102], gr_we[101], dest[100:96], alu_result[95:64], rt_value[63:32], pc[31:0]}.
- es_load_mem_bus  in  7  {width[6:5], sign[4], lr[3:2], addr_lo[1:0]}. Width encoding: 11 word, 10 half, 01 byte, 00 partial. lr: 10 LWL, 01 LWR.
- es_ex  in  1  execute-side exception summary for this bundle.
- es_ex_bus  in  EX_WD  exception side-bus, registered with the bundle.
- data_sram_rdata  in  32  read data, valid exactly one cycle after the request issued in execute.
- ws_allowin  in  1  write-back can accept.
- ms_to_ws_valid  out  1  bundle offered to write-back.
- ms_to_ws_bus  out  70  {gr_we[69], dest[68:64], final_result[63:32], pc[31:0]}.
- ms_ex_bus  out  EX_WD  registered es_ex_bus.
- ms_ex  out  1  ms_valid & registered es_ex.
- flush  in  1  CP0 flush; kills the held bundle.
- ms_write_reg  out  1  ms_valid & gr_we (hazard unit).
- ms_reg_dest  out  5  registered dest.
- ms_to_ds_bus  out  32  final_result (bypass).

## Operation
- Pipeline register: captures es_to_ms_bus, es_load_mem_bus, es_ex, es_ex_bus when es_to_ms_valid & ms_allowin.
- ms_ready_go = 1. ms_allowin = !ms_valid | ws_allowin. ms_to_ws_valid = ms_valid.
- ms_valid: reset or flush → 0; else if ms_allowin → es_to_ms_valid. Flush has priority over a simultaneous accept.
- Read-data capture: the flag ms_first is set to 1 the cycle after an accept and cleared otherwise. Selected data = ms_first ? data_sram_rdata : rdata_buf. rdata_buf is loaded from data_sram_rdata whenever ms_first = 1, so a stalled load keeps correct data after the SRAM output changes.
- Byte lane b = addr_lo.
  - Byte load: data[8b+7:8b], sign- or zero-extended per sign.
  - Half load: addr_lo[1] selects data[31:16] or data[15:0], then extended.
  - Word load: data unchanged.
- LWL (byte offsets 0/1/2/3):
  - 0: {d[7:0], rt[23:0]}
  - 1: {d[15:0], rt[15:0]}
  - 2: {d[23:0], rt[7:0]}
  - 3: d
- LWR (byte offsets 0/1/2/3):
  - 0: d
  - 1: {rt[31:24], d[31:8]}
  - 2: {rt[31:16], d[31:16]}
  - 3: {rt[31:8], d[31:24]}
- final_result = res_from_mem ? load_result : alu_result.
- Alignment faults are detected in execute. This stage does not suppress gr_we on exception; write-back gates it.

## Timing
- Reset values: ms_valid = 0, ms_first = 0, rdata_buf = 0, all bus registers 0. Hence ms_to_ws_valid, ms_ex and ms_write_reg are all 0.
- Latency: one cycle. A bundle accepted at edge N is offered to write-back in cycle N+1 and leaves at the first edge where ws_allowin = 1.
- Back-to-back: with ws_allowin held at 1, one bundle per cycle with no bubbles.
- Stall: while ws_allowin = 0 and ms_valid = 1, all outputs hold steady, including final_result, which comes from rdata_buf after the first cycle.
- Flush mid-stall: ms_valid drops next edge. ms_first is cleared. rdata_buf contents become don't-care.
- Reset while stalled: identical to flush.

## Test plan
- LB, rdata 0x80FF_1234, addr_lo 3, sign=1 → final_result 0xFFFF_FF80. LBU, same rdata and address → 0x0000_0080.
- LWL, addr_lo 1, rdata 0xAABB_CCDD, rt 0x1122_3344 → 0xCCDD_3344. LWR, same inputs → 0x11AA_BBCC.
- LW accepted with ws_allowin = 0 for 3 cycles; SRAM rdata changes to 0xDEAD_BEEF after the first cycle. Required: final_result stays at the first-cycle data; bundle issued exactly once when ws_allowin rises.
- Non-load ADD, alu_result 0x0000_0010, streamed back-to-back with ws_allowin = 1 → one bundle per cycle; ms_to_ds_bus = 0x10 and ms_write_reg = 1 in the cycle after accept.
- flush asserted together with es_to_ms_valid & ms_allowin → ms_valid = 0 next cycle; ms_ex = 0.
- es_ex = 1 bundle → ms_ex = 1 for exactly the cycles ms_valid = 1; ms_ex_bus equals the input captured on the accept edge.
